// File: rtl/multi_core_boot_sequencer.sv
// Boot and run-monitor engine: preloads shared data memory, streams INSTR/REG/BAR/PC
// packets to each core in turn, then reports magic-address stores from the running cores.
package multi_core_boot_sequencer_pkg;
  typedef enum logic [2:0] {
    NET_NULL  = 3'd0,
    NET_INSTR = 3'd1,
    NET_REG   = 3'd2,
    NET_BAR   = 3'd3,
    NET_PC    = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [4:0]  net_id;
    net_op_e     op;
    logic [1:0]  reserved;
    logic [9:0]  net_addr;
    logic [31:0] net_data;
  } net_packet_s;
endpackage

module multi_core_boot_sequencer
  import multi_core_boot_sequencer_pkg::*;
#(
  parameter int unsigned num_cores_p   = 2,
  parameter int unsigned data_words_p  = 1024,
  parameter int unsigned instr_words_p = 1024,
  parameter int unsigned reg_words_p   = 64,
  parameter logic [31:0] bar_mask_p    = 32'h2,
  parameter logic [9:0]  bar_addr_p    = 10'd24,
  parameter logic [31:0] start_pc_p    = 32'h0,
  parameter logic [31:0] timeout_p     = 32'd1_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  output logic                           img_req_o,
  output logic [1:0]                     img_sel_o,
  output logic [31:0]                    img_idx_o,
  input  logic                           img_valid_i,
  input  logic [39:0]                    img_data_i,
  output logic                           mem_valid_o,
  output logic [31:0]                    mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  input  logic                           mem_ready_i,
  output logic                           mem_select_o,
  output net_packet_s                    net_packet_o,
  input  logic                           net_ready_i,
  input  logic [num_cores_p-1:0]         mon_valid_i,
  input  logic [32*num_cores_p-1:0]      mon_addr_i,
  input  logic [32*num_cores_p-1:0]      mon_data_i,
  output logic                           event_valid_o,
  output logic [$clog2(num_cores_p):0]   event_core_o,
  output logic [1:0]                     event_kind_o,
  output logic [31:0]                    event_data_o,
  output logic [31:0]                    event_cycle_o,
  output logic                           event_drop_o,
  output logic                           busy_o,
  output logic                           running_o,
  output logic                           finished_o,
  output logic                           timeout_o,
  output logic [num_cores_p-1:0]         core_done_o,
  output logic [num_cores_p-1:0]         core_fail_o
);

  localparam int unsigned core_w_lp = $clog2(num_cores_p) + 1;
  localparam logic [31:0] data_last_lp  = 32'(data_words_p - 1);
  localparam logic [31:0] instr_last_lp = 32'(instr_words_p - 1);
  localparam logic [31:0] reg_last_lp   = 32'(reg_words_p - 1);
  localparam logic [core_w_lp-1:0] core_last_lp = core_w_lp'(num_cores_p - 1);

  localparam logic [1:0] kind_fail_lp = 2'd0;
  localparam logic [1:0] kind_done_lp = 2'd1;
  localparam logic [1:0] kind_code_lp = 2'd2;
  localparam logic [1:0] kind_pass_lp = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE, ST_LOAD_DATA, ST_LOAD_INSTR, ST_LOAD_REG, ST_SEND_BAR,
    ST_SEND_PC, ST_SEND_NULL, ST_RUN, ST_FINISH
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            idx_q, idx_d;
  logic                   fetched_q, fetched_d;
  logic [39:0]            data_q, data_d;
  logic [core_w_lp-1:0]   core_q, core_d;
  logic                   mem_sel_q, mem_sel_d;
  logic [31:0]            cycle_q, cycle_d;
  logic [num_cores_p-1:0] done_q, done_d;
  logic [num_cores_p-1:0] fail_q, fail_d;
  logic                   timeout_q, timeout_d;
  logic                   ev_valid_q, ev_valid_d;
  logic [core_w_lp-1:0]   ev_core_q, ev_core_d;
  logic [1:0]             ev_kind_q, ev_kind_d;
  logic [31:0]            ev_data_q, ev_data_d;
  logic [31:0]            ev_cycle_q, ev_cycle_d;
  logic                   ev_drop_q, ev_drop_d;

  logic                   issue_ready;
  logic [31:0]            load_last;
  logic                   mon_hit;
  logic                   mon_found;
  logic [1:0]             mon_kind;
  logic                   unused_data_bits;

  assign unused_data_bits = ^data_q[39:38];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      fetched_q  <= 1'b0;
      data_q     <= '0;
      core_q     <= '0;
      mem_sel_q  <= 1'b0;
      cycle_q    <= '0;
      done_q     <= '0;
      fail_q     <= '0;
      timeout_q  <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_core_q  <= '0;
      ev_kind_q  <= '0;
      ev_data_q  <= '0;
      ev_cycle_q <= '0;
      ev_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fetched_q  <= fetched_d;
      data_q     <= data_d;
      core_q     <= core_d;
      mem_sel_q  <= mem_sel_d;
      cycle_q    <= cycle_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      ev_valid_q <= ev_valid_d;
      ev_core_q  <= ev_core_d;
      ev_kind_q  <= ev_kind_d;
      ev_data_q  <= ev_data_d;
      ev_cycle_q <= ev_cycle_d;
      ev_drop_q  <= ev_drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fetched_d   = fetched_q;
    data_d      = data_q;
    core_d      = core_q;
    mem_sel_d   = mem_sel_q;
    cycle_d     = cycle_q;
    done_d      = done_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    ev_valid_d  = 1'b0;
    ev_core_d   = '0;
    ev_kind_d   = '0;
    ev_data_d   = '0;
    ev_cycle_d  = '0;
    ev_drop_d   = 1'b0;
    img_req_o   = 1'b0;
    img_sel_o   = 2'd0;
    img_idx_o   = '0;
    mem_valid_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    net_packet_o = '0;
    issue_ready = 1'b0;
    load_last   = '0;
    mon_hit     = 1'b0;
    mon_found   = 1'b0;
    mon_kind    = '0;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start_i) begin
          state_d   = ST_LOAD_DATA;
          idx_d     = '0;
          fetched_d = 1'b0;
          core_d    = '0;
          mem_sel_d = 1'b0;
          done_d    = '0;
          fail_d    = '0;
          timeout_d = 1'b0;
        end
      end

      ST_LOAD_DATA, ST_LOAD_INSTR, ST_LOAD_REG: begin
        case (state_q)
          ST_LOAD_DATA:  load_last = data_last_lp;
          ST_LOAD_INSTR: load_last = instr_last_lp;
          default:       load_last = reg_last_lp;
        endcase
        if (!fetched_q) begin
          img_req_o = 1'b1;
          img_idx_o = idx_q;
          case (state_q)
            ST_LOAD_DATA:  img_sel_o = 2'd0;
            ST_LOAD_INSTR: img_sel_o = 2'd1;
            default:       img_sel_o = 2'd2;
          endcase
          if (img_valid_i) begin
            data_d    = img_data_i;
            fetched_d = 1'b1;
          end
        end else begin
          // Issue side drives only from captured registers so a stall cannot disturb it.
          case (state_q)
            ST_LOAD_DATA: begin
              issue_ready = mem_ready_i;
              mem_valid_o = 1'b1;
              mem_addr_o  = {idx_q[29:0], 2'b00};
              mem_wdata_o = data_q[31:0];
            end
            ST_LOAD_INSTR: begin
              issue_ready           = net_ready_i;
              net_packet_o.net_id   = 5'(core_q) + 5'd1;
              net_packet_o.op       = NET_INSTR;
              net_packet_o.net_addr = idx_q[9:0];
              net_packet_o.net_data = {16'b0, data_q[15:0]};
            end
            default: begin
              issue_ready           = net_ready_i;
              net_packet_o.net_id   = 5'(core_q) + 5'd1;
              net_packet_o.op       = NET_REG;
              net_packet_o.net_addr = {4'b0, data_q[37:32]};
              net_packet_o.net_data = data_q[31:0];
            end
          endcase
          if (issue_ready) begin
            fetched_d = 1'b0;
            if (idx_q == load_last) begin
              idx_d = '0;
              case (state_q)
                ST_LOAD_DATA:  state_d = ST_LOAD_INSTR;
                ST_LOAD_INSTR: state_d = ST_LOAD_REG;
                default:       state_d = ST_SEND_BAR;
              endcase
            end else begin
              idx_d = idx_q + 32'd1;
            end
          end
        end
      end

      ST_SEND_BAR: begin
        net_packet_o.net_id   = 5'(core_q) + 5'd1;
        net_packet_o.op       = NET_BAR;
        net_packet_o.net_addr = bar_addr_p;
        net_packet_o.net_data = bar_mask_p;
        if (net_ready_i) state_d = ST_SEND_PC;
      end

      ST_SEND_PC: begin
        net_packet_o.net_id   = 5'(core_q) + 5'd1;
        net_packet_o.op       = NET_PC;
        net_packet_o.net_data = start_pc_p;
        if (net_ready_i) begin
          if (core_q == core_last_lp) begin
            state_d = ST_SEND_NULL;
          end else begin
            core_d  = core_q + core_w_lp'(1);
            state_d = ST_LOAD_INSTR;
          end
        end
      end

      ST_SEND_NULL: begin
        if (net_ready_i) begin
          mem_sel_d = 1'b1;
          cycle_d   = '0;
          state_d   = ST_RUN;
        end
      end

      ST_RUN: begin
        cycle_d = (cycle_q == 32'hFFFF_FFFF) ? cycle_q : cycle_q + 32'd1;
        for (int c = 0; c < int'(num_cores_p); c++) begin
          if (mon_valid_i[c]) begin
            mon_hit = 1'b1;
            case (mon_addr_i[32*c +: 32])
              32'hDEAD_DEAD: begin
                mon_kind  = kind_fail_lp;
                fail_d[c] = 1'b1;
                done_d[c] = 1'b1;
              end
              32'h600D_BEEF: begin
                mon_kind  = kind_done_lp;
                done_d[c] = 1'b1;
              end
              32'hC0DE_C0DE: mon_kind = kind_code_lp;
              32'hC0FF_EEEE: mon_kind = kind_pass_lp;
              default:       mon_hit  = 1'b0;
            endcase
            if (mon_hit) begin
              if (!mon_found) begin
                mon_found  = 1'b1;
                ev_valid_d = 1'b1;
                ev_core_d  = core_w_lp'(c);
                ev_kind_d  = mon_kind;
                ev_data_d  = mon_data_i[32*c +: 32];
                ev_cycle_d = cycle_q;
              end else begin
                ev_drop_d = 1'b1;
              end
            end
          end
        end
        if (&done_d) begin
          state_d = ST_FINISH;
        end else if (({1'b0, cycle_q} + 33'd1) >= {1'b0, timeout_p}) begin
          timeout_d = 1'b1;
          state_d   = ST_FINISH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_select_o  = mem_sel_q;
  assign event_valid_o = ev_valid_q;
  assign event_core_o  = ev_core_q;
  assign event_kind_o  = ev_kind_q;
  assign event_data_o  = ev_data_q;
  assign event_cycle_o = ev_cycle_q;
  assign event_drop_o  = ev_drop_q;
  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign running_o     = (state_q == ST_RUN);
  assign finished_o    = (state_q == ST_FINISH);
  assign timeout_o     = timeout_q;
  assign core_done_o   = done_q;
  assign core_fail_o   = fail_q;

endmodule

// File: tb/tb_multi_core_boot_sequencer.sv
// Scoreboard bench for multi_core_boot_sequencer: 2 cores, 4-word images, 100-cycle watchdog.
module tb_multi_core_boot_sequencer;
  import multi_core_boot_sequencer_pkg::*;

  localparam int N = 2;
  localparam int D = 4;
  localparam int I = 4;
  localparam int R = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic              img_req_o;
  logic [1:0]        img_sel_o;
  logic [31:0]       img_idx_o;
  logic              img_valid_i;
  logic [39:0]       img_data_i;
  logic              mem_valid_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ready_i;
  logic              mem_select_o;
  net_packet_s       net_packet_o;
  logic              net_ready_i;
  logic [N-1:0]      mon_valid_i;
  logic [32*N-1:0]   mon_addr_i;
  logic [32*N-1:0]   mon_data_i;
  logic              event_valid_o;
  logic [1:0]        event_core_o;
  logic [1:0]        event_kind_o;
  logic [31:0]       event_data_o;
  logic [31:0]       event_cycle_o;
  logic              event_drop_o;
  logic              busy_o;
  logic              running_o;
  logic              finished_o;
  logic              timeout_o;
  logic [N-1:0]      core_done_o;
  logic [N-1:0]      core_fail_o;

  int checks = 0;
  int errors = 0;
  int img_lat = 0;
  int req_age = 0;
  logic [31:0] tb_run_cyc;

  typedef struct packed {
    logic [1:0]  core;
    logic [1:0]  kind;
    logic [31:0] data;
    logic [31:0] cyc;
    logic        drop;
  } ev_t;

  logic [63:0]  exp_mem[$];
  net_packet_s  exp_pkt[$];
  ev_t          exp_ev[$];

  multi_core_boot_sequencer #(
    .num_cores_p(N), .data_words_p(D), .instr_words_p(I), .reg_words_p(R),
    .bar_mask_p(32'h2), .bar_addr_p(10'd24), .start_pc_p(32'h0), .timeout_p(32'd100)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .img_req_o(img_req_o), .img_sel_o(img_sel_o), .img_idx_o(img_idx_o),
    .img_valid_i(img_valid_i), .img_data_i(img_data_i),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_select_o(mem_select_o),
    .net_packet_o(net_packet_o), .net_ready_i(net_ready_i),
    .mon_valid_i(mon_valid_i), .mon_addr_i(mon_addr_i), .mon_data_i(mon_data_i),
    .event_valid_o(event_valid_o), .event_core_o(event_core_o), .event_kind_o(event_kind_o),
    .event_data_o(event_data_o), .event_cycle_o(event_cycle_o), .event_drop_o(event_drop_o),
    .busy_o(busy_o), .running_o(running_o), .finished_o(finished_o), .timeout_o(timeout_o),
    .core_done_o(core_done_o), .core_fail_o(core_fail_o)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] img_fn(input logic [1:0] sel, input logic [31:0] idx);
    logic [5:0] ra;
    ra = 6'(idx * 7 + 3);
    case (sel)
      2'd0:    img_fn = {8'h5A, 32'hD000_0000 + idx * 32'h0101_0101};
      2'd1:    img_fn = {8'hA5, 16'hBEEF, 16'h1000 + idx[15:0]};
      default: img_fn = {2'b10, ra, 32'h7000_0000 + idx};
    endcase
  endfunction

  // Image source with programmable latency; zero latency answers in the request cycle.
  assign img_valid_i = img_req_o && (req_age >= img_lat);
  assign img_data_i  = img_valid_i ? img_fn(img_sel_o, img_idx_o) : 40'h0;

  always @(posedge clk) begin
    if (img_req_o && !img_valid_i) req_age <= req_age + 1;
    else req_age <= 0;
    if (reset || !running_o) tb_run_cyc <= 32'd0;
    else tb_run_cyc <= tb_run_cyc + 32'd1;
  end

  logic        prev_mem_stall, prev_pkt_stall;
  logic [64:0] prev_mem;
  net_packet_s prev_pkt;

  always @(negedge clk) begin
    logic [63:0] em;
    net_packet_s ep;
    ev_t ee;
    if (reset) begin
      prev_mem_stall = 1'b0;
      prev_pkt_stall = 1'b0;
    end else begin
      if (prev_mem_stall) begin
        checks++;
        if ({mem_valid_o, mem_addr_o, mem_wdata_o} !== prev_mem) begin
          errors++;
          $display("FAIL mem_hold got %h want %h", {mem_valid_o, mem_addr_o, mem_wdata_o}, prev_mem);
        end
      end
      if (mem_valid_o && mem_ready_i) begin
        checks++;
        if (exp_mem.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected got %h/%h want none", mem_addr_o, mem_wdata_o);
        end else begin
          em = exp_mem.pop_front();
          if ({mem_addr_o, mem_wdata_o} !== em) begin
            errors++;
            $display("FAIL mem_write got %h/%h want %h/%h", mem_addr_o, mem_wdata_o, em[63:32], em[31:0]);
          end
        end
      end
      prev_mem_stall = mem_valid_o && !mem_ready_i;
      prev_mem = {mem_valid_o, mem_addr_o, mem_wdata_o};

      if (prev_pkt_stall) begin
        checks++;
        if (net_packet_o !== prev_pkt) begin
          errors++;
          $display("FAIL pkt_hold got %h want %h", net_packet_o, prev_pkt);
        end
      end
      if (net_packet_o.op != NET_NULL && net_ready_i) begin
        checks++;
        if (exp_pkt.size() == 0) begin
          errors++;
          $display("FAIL pkt_unexpected got %h want none", net_packet_o);
        end else begin
          ep = exp_pkt.pop_front();
          if (net_packet_o !== ep) begin
            errors++;
            $display("FAIL pkt got %h want %h", net_packet_o, ep);
          end
        end
      end
      prev_pkt_stall = (net_packet_o.op != NET_NULL) && !net_ready_i;
      prev_pkt = net_packet_o;

      if (event_valid_o) begin
        checks++;
        if (exp_ev.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected got core %0d kind %0d want none", event_core_o, event_kind_o);
        end else begin
          ee = exp_ev.pop_front();
          if ({event_core_o, event_kind_o, event_data_o, event_cycle_o, event_drop_o} !== ee) begin
            errors++;
            $display("FAIL event got %h want %h",
                     {event_core_o, event_kind_o, event_data_o, event_cycle_o, event_drop_o}, ee);
          end
        end
      end
    end
  end

  task automatic push_boot_expect();
    logic [39:0] w;
    net_packet_s p;
    for (int i = 0; i < D; i++) begin
      w = img_fn(2'd0, 32'(i));
      exp_mem.push_back({32'(i * 4), w[31:0]});
    end
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < I; i++) begin
        w = img_fn(2'd1, 32'(i));
        p = '0; p.net_id = 5'(c + 1); p.op = NET_INSTR;
        p.net_addr = 10'(i); p.net_data = {16'b0, w[15:0]};
        exp_pkt.push_back(p);
      end
      for (int i = 0; i < R; i++) begin
        w = img_fn(2'd2, 32'(i));
        p = '0; p.net_id = 5'(c + 1); p.op = NET_REG;
        p.net_addr = {4'b0, w[37:32]}; p.net_data = w[31:0];
        exp_pkt.push_back(p);
      end
      p = '0; p.net_id = 5'(c + 1); p.op = NET_BAR; p.net_addr = 10'd24; p.net_data = 32'h2;
      exp_pkt.push_back(p);
      p = '0; p.net_id = 5'(c + 1); p.op = NET_PC; p.net_addr = 10'd0; p.net_data = 32'h0;
      exp_pkt.push_back(p);
    end
  endtask

  task automatic push_ev(input int core, input int kind, input logic [31:0] data, input logic drop);
    ev_t e;
    e.core = 2'(core); e.kind = 2'(kind); e.data = data; e.cyc = tb_run_cyc; e.drop = drop;
    exp_ev.push_back(e);
  endtask

  task automatic check_queues_empty(input string name);
    checks++;
    if (exp_mem.size() != 0 || exp_pkt.size() != 0 || exp_ev.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got mem %0d pkt %0d ev %0d left want 0", name,
               exp_mem.size(), exp_pkt.size(), exp_ev.size());
    end
  endtask

  // Caller raises start_i just after an edge; counts edges until RUN is visible.
  task automatic wait_running(input int bound, output int n);
    n = 0;
    while (!running_o && n < bound) begin
      @(posedge clk); #1;
      n++;
      start_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({img_req_o, img_sel_o, img_idx_o, mem_valid_o, mem_addr_o, mem_wdata_o, mem_select_o,
           net_packet_o, event_valid_o, event_core_o, event_kind_o, event_data_o, event_cycle_o,
           event_drop_o, busy_o, running_o, finished_o, timeout_o, core_done_o, core_fail_o} !== '0) begin
        errors++;
        $display("FAIL idle_outputs cycle %0d got pkt %h busy %b sel %b want all zero",
                 k, net_packet_o, busy_o, mem_select_o);
      end
    end
  endtask

  task automatic test_boot();
    int n;
    img_lat = 0;
    push_boot_expect();
    start_i = 1'b1;
    wait_running(200, n);
    checks++;
    if (n != 46 || !running_o) begin
      errors++;
      $display("FAIL boot_time got %0d running %b want 46", n, running_o);
    end
    checks++;
    if (mem_select_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL boot_run_flags got sel %b busy %b want 1 1", mem_select_o, busy_o);
    end
    check_queues_empty("boot");
  endtask

  task automatic test_monitor();
    repeat (2) begin @(posedge clk); #1; end
    mon_valid_i = 2'b01; mon_addr_i = {32'h0, 32'hC0FF_EEEE}; mon_data_i = {32'h0, 32'd7};
    push_ev(0, 3, 32'd7, 1'b0);
    @(posedge clk); #1;
    mon_valid_i = 2'b10; mon_addr_i = {32'h1234_5678, 32'h0}; mon_data_i = {32'd99, 32'h0};
    @(posedge clk); #1;
    mon_valid_i = 2'b10; mon_addr_i = {32'hC0DE_C0DE, 32'h0}; mon_data_i = {32'd55, 32'h0};
    push_ev(1, 2, 32'd55, 1'b0);
    @(posedge clk); #1;
    mon_valid_i = 2'b11; mon_addr_i = {32'h600D_BEEF, 32'hDEAD_DEAD}; mon_data_i = {32'd10, 32'd9};
    push_ev(0, 0, 32'd9, 1'b1);
    @(posedge clk); #1;
    mon_valid_i = 2'b00;
    checks++;
    if (finished_o !== 1'b1 || core_done_o !== 2'b11 || core_fail_o !== 2'b01 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL monitor_finish got fin %b done %b fail %b to %b want 1 11 01 0",
               finished_o, core_done_o, core_fail_o, timeout_o);
    end
    @(posedge clk); #1;
    checks++;
    if (event_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL event_pulse got %b want 0", event_valid_o);
    end
    check_queues_empty("monitor");
  endtask

  task automatic test_timeout();
    int n;
    push_boot_expect();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (finished_o !== 1'b0 || core_done_o !== 2'b00 || core_fail_o !== 2'b00 ||
        mem_select_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear got fin %b done %b fail %b sel %b busy %b want 0 00 00 0 1",
               finished_o, core_done_o, core_fail_o, mem_select_o, busy_o);
    end
    wait_running(200, n);
    checks++;
    if (n != 45) begin
      errors++;
      $display("FAIL reboot_time got %0d want 45", n);
    end
    n = 0;
    while (!finished_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 100 || timeout_o !== 1'b1 || core_done_o !== 2'b00) begin
      errors++;
      $display("FAIL timeout got cycles %0d to %b done %b want 100 1 00", n, timeout_o, core_done_o);
    end
    check_queues_empty("timeout");
  endtask

  task automatic test_backpressure();
    int n, mem_stall, net_stall;
    bit did_mem, did_net;
    img_lat = 3;
    push_boot_expect();
    start_i = 1'b1;
    n = 0; mem_stall = 0; net_stall = 0; did_mem = 0; did_net = 0;
    while (!running_o && n < 3000) begin
      @(posedge clk); #1;
      n++;
      start_i = 1'b0;
      if (mem_stall > 0) begin
        mem_stall--;
        if (mem_stall == 0) mem_ready_i = 1'b1;
      end else if (!did_mem && mem_valid_o) begin
        mem_ready_i = 1'b0; mem_stall = 3; did_mem = 1;
      end
      if (net_stall > 0) begin
        net_stall--;
        if (net_stall == 0) net_ready_i = 1'b1;
      end else if (!did_net && net_packet_o.op == NET_REG && net_packet_o.net_id == 5'd1) begin
        net_ready_i = 1'b0; net_stall = 5; did_net = 1;
      end
    end
    // 46 base + 3 per fetched element (20 elements) + 3 memory stall + 5 network stall.
    checks++;
    if (n != 114 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_boot_time got %0d to %b want 114 0", n, timeout_o);
    end
    img_lat = 0;
    @(posedge clk); #1;
    mon_valid_i = 2'b10; mon_addr_i = {32'h600D_BEEF, 32'h0}; mon_data_i = {32'd1, 32'h0};
    push_ev(1, 1, 32'd1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (running_o !== 1'b1 || core_done_o !== 2'b10) begin
      errors++;
      $display("FAIL partial_done got run %b done %b want 1 10", running_o, core_done_o);
    end
    mon_valid_i = 2'b01; mon_addr_i = {32'h0, 32'h600D_BEEF}; mon_data_i = {32'h0, 32'd2};
    push_ev(0, 1, 32'd2, 1'b0);
    @(posedge clk); #1;
    mon_valid_i = 2'b00;
    @(posedge clk); #1;
    checks++;
    if (finished_o !== 1'b1 || core_done_o !== 2'b11 || core_fail_o !== 2'b00 || timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL all_done got fin %b done %b fail %b to %b want 1 11 00 0",
               finished_o, core_done_o, core_fail_o, timeout_o);
    end
    check_queues_empty("backpressure");
  endtask

  task automatic test_mid_reset();
    int n;
    push_boot_expect();
    start_i = 1'b1;
    n = 0;
    while (net_packet_o.op != NET_INSTR && n < 200) begin
      @(posedge clk); #1;
      n++;
      start_i = 1'b0;
    end
    checks++;
    if (net_packet_o.op != NET_INSTR) begin
      errors++;
      $display("FAIL reach_instr got op %0d want %0d", net_packet_o.op, NET_INSTR);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || mem_select_o !== 1'b0 || net_packet_o !== '0 ||
        core_done_o !== 2'b00 || finished_o !== 1'b0 || img_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got busy %b sel %b pkt %h done %b fin %b want 0 0 0 00 0",
               busy_o, mem_select_o, net_packet_o, core_done_o, finished_o);
    end
    exp_mem.delete();
    exp_pkt.delete();
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy_o !== 1'b0 || net_packet_o !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got busy %b pkt %h want 0 0", busy_o, net_packet_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_i = 1'b0;
    mem_ready_i = 1'b1; net_ready_i = 1'b1;
    mon_valid_i = '0; mon_addr_i = '0; mon_data_i = '0;
    test_reset();
    test_boot();
    test_monitor();
    test_timeout();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
